// File: rtl/clock_pkg.sv
// Shared types and default timing for the board clock/reset bring-up logic.
package clock_pkg;

  typedef enum logic [1:0] {
    HOLD      = 2'd0,
    WAIT_LOCK = 2'd1,
    RUN       = 2'd2,
    FAULT     = 2'd3
  } reset_seq_state_t;

  localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
  localparam int DEF_HOLD_CYCLES     = 16;
  localparam int DEF_SETTLE_CYCLES   = 64;
  localparam int DEF_LOCK_TIMEOUT    = 100_000;
  localparam int DEF_MAX_RETRIES     = 3;

  // Width of a counter that must hold 0..n, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/reset_sequencer_debounce.sv
// Push-button conditioning: 2-flop synchronizer, stability counter, accepted level
// and a single-cycle pulse on each accepted 0->1 transition.
module debounce import clock_pkg::*; #(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic level,
  output logic press
);

  localparam int CW = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      cnt    <= '0;
      level  <= 1'b0;
      press  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], btn};
      press  <= 1'b0;
      // Any return to the accepted level restarts the stability window.
      if (sync_q[1] == level) begin
        cnt <= '0;
      end else if (cnt >= CNT_LAST) begin
        level <= sync_q[1];
        press <= sync_q[1];
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// Board reset sequencer: holds the clock-manager reset, waits for stable lock,
// retries on lock timeout and latches a fault once retries are exhausted.
module reset_sequencer import clock_pkg::*; #(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int SETTLE_CYCLES   = DEF_SETTLE_CYCLES,
  parameter int LOCK_TIMEOUT    = DEF_LOCK_TIMEOUT,
  parameter int MAX_RETRIES     = DEF_MAX_RETRIES
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_reset,
  input  logic locked,
  output logic reset_out,
  output logic done,
  output logic fault
);

  localparam int HW = cnt_w(HOLD_CYCLES);
  localparam int SW = cnt_w(SETTLE_CYCLES);
  localparam int TW = cnt_w(LOCK_TIMEOUT);
  localparam int RW = cnt_w(MAX_RETRIES);

  localparam logic [HW-1:0] HOLD_LAST    = HW'(HOLD_CYCLES - 1);
  localparam logic [SW-1:0] SETTLE_LAST  = SW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT - 1);
  localparam logic [RW-1:0] RETRY_MAX    = RW'(MAX_RETRIES);

  reset_seq_state_t state, state_nxt;
  logic [HW-1:0] hold_cnt, hold_nxt;
  logic [SW-1:0] settle_cnt, settle_nxt;
  logic [TW-1:0] timeout_cnt, timeout_nxt;
  logic [RW-1:0] retries, retries_nxt;
  logic [1:0]    lock_sync;
  logic          lock_s;
  logic          btn_level;
  logic          press;

  debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_reset),
    .level (btn_level),
    .press (press)
  );

  // Lock seen while the clock manager is still in reset is stale, so the
  // synchronizer is flushed for the whole HOLD phase.
  always_ff @(posedge clk) begin
    if (reset || state == HOLD) lock_sync <= '0;
    else                        lock_sync <= {lock_sync[0], locked};
  end

  assign lock_s = lock_sync[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= HOLD;
      hold_cnt    <= '0;
      settle_cnt  <= '0;
      timeout_cnt <= '0;
      retries     <= '0;
    end else begin
      state       <= state_nxt;
      hold_cnt    <= hold_nxt;
      settle_cnt  <= settle_nxt;
      timeout_cnt <= timeout_nxt;
      retries     <= retries_nxt;
    end
  end

  // Counters only advance while their phase continues; every exit clears them,
  // and each stops one short of its limit, so none can wrap.
  always_comb begin
    state_nxt   = state;
    hold_nxt    = '0;
    settle_nxt  = '0;
    timeout_nxt = '0;
    retries_nxt = retries;
    unique case (state)
      HOLD: begin
        if (btn_level)                   hold_nxt  = '0;
        else if (hold_cnt >= HOLD_LAST)  state_nxt = WAIT_LOCK;
        else                             hold_nxt  = hold_cnt + 1'b1;
      end
      WAIT_LOCK: begin
        if (lock_s && settle_cnt >= SETTLE_LAST) begin
          state_nxt = RUN;
        end else if (timeout_cnt >= TIMEOUT_LAST) begin
          if (retries >= RETRY_MAX) begin
            state_nxt = FAULT;
          end else begin
            retries_nxt = retries + 1'b1;
            state_nxt   = HOLD;
          end
        end else begin
          settle_nxt  = lock_s ? settle_cnt + 1'b1 : '0;
          timeout_nxt = timeout_cnt + 1'b1;
        end
      end
      RUN: begin
        retries_nxt = '0;
        if (!lock_s) state_nxt = HOLD;
      end
      FAULT: begin
        state_nxt = FAULT;
      end
    endcase
    if (press) begin
      state_nxt   = HOLD;
      hold_nxt    = '0;
      settle_nxt  = '0;
      timeout_nxt = '0;
      if (state == FAULT) retries_nxt = '0;
    end
  end

  assign reset_out = (state == HOLD) || (state == FAULT);
  assign done      = (state == RUN);
  assign fault     = (state == FAULT);

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench: stimulus queues expected outputs tagged with a cycle number,
// a negedge monitor pops and compares them as those cycles arrive.
module tb_reset_sequencer;

  localparam int DEB = 8, HLD = 4, STL = 3, TMO = 20, MAXR = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic btn_reset = 1'b0;
  logic locked = 1'b1;
  logic reset_out, done, fault;

  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int    c;
    logic  ro;
    logic  dn;
    logic  ft;
    string tag;
  } exp_t;

  exp_t sb[$];

  reset_sequencer #(
    .DEBOUNCE_CYCLES (DEB),
    .HOLD_CYCLES     (HLD),
    .SETTLE_CYCLES   (STL),
    .LOCK_TIMEOUT    (TMO),
    .MAX_RETRIES     (MAXR)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_reset (btn_reset),
    .locked    (locked),
    .reset_out (reset_out),
    .done      (done),
    .fault     (fault)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Keep the scoreboard ordered by cycle so the monitor can pop from the front.
  task automatic exp_at(input int c, input logic ro, input logic dn, input logic ft, input string tag);
    exp_t e;
    int   i;
    e = '{c, ro, dn, ft, tag};
    i = 0;
    while (i < sb.size() && sb[i].c <= c) i++;
    sb.insert(i, e);
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    while (sb.size() > 0 && sb[0].c <= cyc) begin
      e = sb.pop_front();
      n_vec++;
      if (e.c != cyc || reset_out !== e.ro || done !== e.dn || fault !== e.ft) begin
        n_err++;
        $display("FAIL %s cyc=%0d due=%0d got reset_out=%b done=%b fault=%b want reset_out=%b done=%b fault=%b",
                 e.tag, cyc, e.c, reset_out, done, fault, e.ro, e.dn, e.ft);
      end
    end
  end

  initial begin : watchdog
    #50000;
    $display("FAIL watchdog cyc=%0d got no end of stimulus want finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int t;

    // Power-up: reset sampled at edges 1 and 2, locked already high.
    step(2);
    reset = 1'b0;
    exp_at(2,  1'b1, 1'b0, 1'b0, "pwr_reset");
    exp_at(5,  1'b1, 1'b0, 1'b0, "pwr_hold_end");
    exp_at(6,  1'b0, 1'b0, 1'b0, "pwr_release");
    exp_at(10, 1'b0, 1'b0, 1'b0, "pwr_settling");
    exp_at(11, 1'b0, 1'b1, 1'b0, "pwr_done");
    step(12);

    // Bouncing button never stays stable long enough to be accepted.
    t = cyc;
    for (int k = 1; k <= 8; k++) exp_at(t + 5 * k, 1'b0, 1'b1, 1'b0, "bounce");
    for (int k = 0; k < 10; k++) begin
      btn_reset = ~btn_reset;
      step(3);
    end
    step(15);

    // Clean 20-cycle press.
    t = cyc;
    btn_reset = 1'b1;
    exp_at(t + 10, 1'b0, 1'b1, 1'b0, "press_pre");
    exp_at(t + 11, 1'b1, 1'b0, 1'b0, "press_latency");
    exp_at(t + 20, 1'b1, 1'b0, 1'b0, "press_held");
    exp_at(t + 33, 1'b1, 1'b0, 1'b0, "press_hold_tail");
    exp_at(t + 34, 1'b0, 1'b0, 1'b0, "press_release");
    exp_at(t + 38, 1'b0, 1'b0, 1'b0, "press_relock_pre");
    exp_at(t + 39, 1'b0, 1'b1, 1'b0, "press_relock");
    step(20);
    btn_reset = 1'b0;
    step(25);

    // One-cycle lock loss in RUN.
    t = cyc;
    locked = 1'b0;
    exp_at(t + 2,  1'b0, 1'b1, 1'b0, "loss_pre");
    exp_at(t + 3,  1'b1, 1'b0, 1'b0, "loss_hold");
    exp_at(t + 6,  1'b1, 1'b0, 1'b0, "loss_hold_end");
    exp_at(t + 7,  1'b0, 1'b0, 1'b0, "loss_wait");
    exp_at(t + 11, 1'b0, 1'b0, 1'b0, "loss_settle");
    exp_at(t + 12, 1'b0, 1'b1, 1'b0, "loss_redone");
    step(1);
    locked = 1'b1;
    step(15);

    // Lock never returns: two retries, fault on the third timeout.
    t = cyc;
    locked = 1'b0;
    exp_at(t + 3,   1'b1, 1'b0, 1'b0, "tmo_hold0");
    exp_at(t + 7,   1'b0, 1'b0, 1'b0, "tmo_wait1");
    exp_at(t + 26,  1'b0, 1'b0, 1'b0, "tmo1_pre");
    exp_at(t + 27,  1'b1, 1'b0, 1'b0, "tmo1_retry");
    exp_at(t + 31,  1'b0, 1'b0, 1'b0, "tmo_wait2");
    exp_at(t + 50,  1'b0, 1'b0, 1'b0, "tmo2_pre");
    exp_at(t + 51,  1'b1, 1'b0, 1'b0, "tmo2_retry");
    exp_at(t + 55,  1'b0, 1'b0, 1'b0, "tmo_wait3");
    exp_at(t + 74,  1'b0, 1'b0, 1'b0, "tmo3_pre");
    exp_at(t + 75,  1'b1, 1'b0, 1'b1, "fault_set");
    exp_at(t + 150, 1'b1, 1'b0, 1'b1, "fault_sticky");
    step(160);

    // Press clears the fault; then a short lock glitch and a real lock in WAIT_LOCK.
    t = cyc;
    btn_reset = 1'b1;
    exp_at(t + 10, 1'b1, 1'b0, 1'b1, "fault_pre_press");
    exp_at(t + 11, 1'b1, 1'b0, 1'b0, "fault_cleared");
    exp_at(t + 25, 1'b1, 1'b0, 1'b0, "fault_hold_end");
    exp_at(t + 26, 1'b0, 1'b0, 1'b0, "fault_exit_wait");
    step(12);
    btn_reset = 1'b0;
    step(18);
    t = cyc;
    locked = 1'b1;
    for (int k = 1; k <= 6; k++) exp_at(t + k, 1'b0, 1'b0, 1'b0, "glitch");
    step(1);
    locked = 1'b0;
    step(5);
    t = cyc;
    locked = 1'b1;
    exp_at(t + 4, 1'b0, 1'b0, 1'b0, "settle_pre");
    exp_at(t + 5, 1'b0, 1'b1, 1'b0, "settle_done");
    step(8);

    // Reset lands in WAIT_LOCK one cycle before settling would complete.
    t = cyc;
    locked = 1'b0;
    step(7);
    locked = 1'b1;
    step(4);
    reset = 1'b1;
    exp_at(t + 11, 1'b0, 1'b0, 1'b0, "rst_pre");
    exp_at(t + 12, 1'b1, 1'b0, 1'b0, "rst_hold");
    exp_at(t + 15, 1'b1, 1'b0, 1'b0, "rst_hold_end");
    exp_at(t + 16, 1'b0, 1'b0, 1'b0, "rst_wait");
    exp_at(t + 20, 1'b0, 1'b0, 1'b0, "rst_settle");
    exp_at(t + 21, 1'b0, 1'b1, 1'b0, "rst_done");
    step(1);
    reset = 1'b0;
    step(12);

    if (sb.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL scoreboard_drain got %0d pending want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
